ram_ctrl: RTL and testbench

Parametrised single-port RAM with an explicit request/response handshake, configurable access latency and byte-lane write enables. It is the next-generation data/instruction store for the CPU core. It replaces change-detection sequencing with a registered req/ready/resp protocol, and flags out-of-range addresses instead of aliasing them.

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_array.sv | 27 ++
 rtl/ram_ctrl.sv | 119 +++++++++++
 tb/tb_ram_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the request/response RAM controller.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int LANES      = DEF_DATA_W / 8;
    localparam int CNT_W      = 4;

    function automatic int lanes_of(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Word storage: synchronous byte-lane write, combinational read.
module ram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ram_ctrl.sv
// RAM controller: latches one request, waits LATENCY cycles, performs the
// access and returns a one-cycle resp with rdata/err. Out-of-range flags err.
module ram_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req,
    input  logic                          wr,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [lanes_of(DATA_W)-1:0]   be,
    output logic                          ready,
    output logic                          resp,
    output logic [DATA_W-1:0]             rdata,
    output logic                          err,
    output state_t                        dbg_state
);

    localparam int NL    = lanes_of(DATA_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    // Handshake: a request is taken on a rising edge where req=1 and ready=1;
    // resp pulses for exactly one cycle per taken request, with rdata/err valid.

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [NL-1:0]      be_q;
    logic               resp_q, err_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  mem_rdata;
    logic               in_range;
    logic               accept;
    logic               mem_we;

    // Full-width compare so addresses beyond DEPTH never alias into the array.
    assign in_range = ({1'b0, addr_q} < DEPTH_X);
    assign accept   = (state_q == IDLE) && req;
    assign mem_we   = rst_n && (state_q == ACCESS) && wr_q && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = ACCESS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= (state_q == ACCESS);
            if (state_q == ACCESS) begin
                err_q   <= !in_range;
                rdata_q <= (!wr_q && in_range) ? mem_rdata : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= wr;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
        end
    end

    ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .be    (be_q),
        .rdata (mem_rdata)
    );

    assign ready     = (state_q == IDLE);
    assign resp      = resp_q;
    assign rdata     = rdata_q;
    assign err       = resp_q & err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl across LATENCY = 1, 0, 3, 4 with a shared clock.
module tb_ram_ctrl;
    import ram_pkg::*;

    localparam int NI = 4;
    localparam int LATS [NI] = '{1, 0, 3, 4};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_v   [NI];
    logic        wr_v    [NI];
    logic [31:0] addr_v  [NI];
    logic [31:0] wdata_v [NI];
    logic [3:0]  be_v    [NI];
    logic        ready_v [NI];
    logic        resp_v  [NI];
    logic [31:0] rdata_v [NI];
    logic        err_v   [NI];
    state_t      st_v    [NI];

    logic [32:0] exp_q [$];
    logic [31:0] model_mem [NI][32];
    int          checks = 0;
    int          errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ram_ctrl #(
            .DATA_W (32), .ADDR_W (32), .DEPTH (32), .LATENCY (LATS[g])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req_v[g]),
            .wr        (wr_v[g]),
            .addr      (addr_v[g]),
            .wdata     (wdata_v[g]),
            .be        (be_v[g]),
            .ready     (ready_v[g]),
            .resp      (resp_v[g]),
            .rdata     (rdata_v[g]),
            .err       (err_v[g]),
            .dbg_state (st_v[g])
        );
    end

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request when the instance is ready; push its expected result.
    task automatic issue(input int g, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b, input bit commit);
        bit          rdy = 1'b0;
        logic [31:0] nv;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready_v[g]) begin rdy = 1'b1; break; end
        end
        if (!rdy) chk("issue_ready_timeout", 0, 1);
        req_v[g] = 1'b1; wr_v[g] = w; addr_v[g] = a; wdata_v[g] = d; be_v[g] = b;
        if (a >= 32) begin
            exp_q.push_back({1'b1, 32'h0});
        end else if (w) begin
            nv = model_mem[g][a[4:0]];
            for (int i = 0; i < 4; i++) if (b[i]) nv[8*i +: 8] = d[8*i +: 8];
            if (commit) model_mem[g][a[4:0]] = nv;
            exp_q.push_back({1'b0, 32'h0});
        end else begin
            exp_q.push_back({1'b0, model_mem[g][a[4:0]]});
        end
        @(posedge clk);
        #1 req_v[g] = 1'b0;
    endtask

    // Wait for resp, check latency, popped data/err, ready, and pulse width.
    task automatic wait_resp(input int g, input string tag);
        bit          found = 1'b0;
        int          kk = 0;
        logic [32:0] e;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (resp_v[g]) begin found = 1'b1; kk = k; break; end
        end
        chk({tag, "_resp_seen"}, 64'(found), 1);
        e = exp_q.pop_front();
        if (found) begin
            chk({tag, "_latency"}, 64'(kk), 64'(LATS[g] + 1));
            chk({tag, "_rdata"}, 64'(rdata_v[g]), 64'(e[31:0]));
            chk({tag, "_err"}, 64'(err_v[g]), 64'(e[32]));
            chk({tag, "_ready"}, 64'(ready_v[g]), 1);
            @(negedge clk);
            chk({tag, "_resp_width"}, 64'(resp_v[g]), 0);
            chk({tag, "_err_low"}, 64'(err_v[g]), 0);
        end
    endtask

    initial begin
        int n_resp;
        logic [32:0] e;
        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) begin
            req_v[g] = 1'b0; wr_v[g] = 1'b0; addr_v[g] = '0; wdata_v[g] = '0; be_v[g] = '0;
        end

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(ready_v[0]), 1);
        chk("rst_resp", 64'(resp_v[0]), 0);
        chk("rst_rdata", 64'(rdata_v[0]), 0);
        chk("rst_err", 64'(err_v[0]), 0);
        chk("rst_state", 64'(st_v[0]), 64'(IDLE));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("idle_no_resp", 64'(resp_v[0]), 0);
        end

        // Write/read at LATENCY=1
        issue(0, 1, 5, 32'hDEADBEEF, 4'hF, 1); wait_resp(0, "wr5");
        issue(0, 0, 5, 32'h0, 4'h0, 1);        wait_resp(0, "rd5");

        // Byte enables; read result must be 0x11BB33DD
        issue(0, 1, 3, 32'h11223344, 4'hF, 1); wait_resp(0, "wr3a");
        issue(0, 1, 3, 32'hAABBCCDD, 4'h5, 1); wait_resp(0, "wr3b");
        chk("be_model", 64'(model_mem[0][3]), 64'h11BB33DD);
        issue(0, 0, 3, 32'h0, 4'h0, 1);        wait_resp(0, "rd3");
        issue(0, 1, 4, 32'h99999999, 4'h0, 1); wait_resp(0, "wr4_be0");

        // Out-of-range: no aliasing onto addr 8
        issue(0, 1, 8, 32'h55AA55AA, 4'hF, 1); wait_resp(0, "wr8");
        issue(0, 1, 40, 32'hFFFFFFFF, 4'hF, 1); wait_resp(0, "wr40");
        issue(0, 0, 40, 32'h0, 4'h0, 1);       wait_resp(0, "rd40");
        issue(0, 0, 32'h80000008, 32'h0, 4'h0, 1); wait_resp(0, "rd_hi");
        issue(0, 0, 8, 32'h0, 4'h0, 1);        wait_resp(0, "rd8");

        // LATENCY=3: a req pulsed during WAIT is ignored
        issue(2, 1, 9, 32'h0BADBEEF, 4'hF, 1); wait_resp(2, "l3_wr9");
        issue(2, 0, 9, 32'h0, 4'h0, 1);
        @(negedge clk);
        chk("l3_busy_state", 64'(st_v[2]), 64'(WAIT));
        req_v[2] = 1'b1; wr_v[2] = 1'b1; addr_v[2] = 9; wdata_v[2] = 32'hFFFFFFFF; be_v[2] = 4'hF;
        @(posedge clk);
        #1 req_v[2] = 1'b0;
        n_resp = 0;
        e = exp_q.pop_front();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (resp_v[2]) begin
                n_resp++;
                chk("l3_busy_rdata", 64'(rdata_v[2]), 64'(e[31:0]));
            end
        end
        chk("l3_busy_resp_count", 64'(n_resp), 1);
        issue(2, 0, 9, 32'h0, 4'h0, 1); wait_resp(2, "l3_rd9");

        // LATENCY=0 back-to-back: resp every second cycle
        issue(1, 1, 2, 32'h12345678, 4'hF, 1); wait_resp(1, "l0_wr2");
        req_v[1] = 1'b1; wr_v[1] = 1'b0; addr_v[1] = 2;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("b2b_resp", 64'(resp_v[1]), 64'(k % 2));
            if (k % 2 == 1) chk("b2b_rdata", 64'(rdata_v[1]), 64'(model_mem[1][2]));
        end
        req_v[1] = 1'b0;
        repeat (3) @(negedge clk);

        // LATENCY=4: reset during WAIT aborts the write
        issue(3, 1, 7, 32'h01234567, 4'hF, 1); wait_resp(3, "l4_wr7");
        issue(3, 1, 7, 32'hCAFEF00D, 4'hF, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_resp = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_v[3]) n_resp++;
        end
        chk("abort_no_resp", 64'(n_resp), 0);
        chk("abort_ready", 64'(ready_v[3]), 1);
        issue(3, 0, 7, 32'h0, 4'h0, 1); wait_resp(3, "l4_rd7");
        chk("abort_old_value", 64'(model_mem[3][7]), 64'h01234567);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
